// File: rtl/axi_mem_responder.sv
// AXI subordinate backed by a DEPTH x 32-bit word memory.
// Independent read and write burst engines; reads see writes from the cycle after the write edge.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module axi_mem_responder #(
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 4,
   parameter int ADDR_WIDTH   = `ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   // write address
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [3:0]            AWID,
   input  logic [3:0]            AWLEN,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   // write data
   input  logic                  WVALID,
   output logic                  WREADY,
   input  logic                  WLAST,
   input  logic [3:0]            WID,
   input  logic [31:0]           WDATA,
   // write response
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic [3:0]            BID,
   // read address
   input  logic                  ARVALID,
   output logic                  ARREADY,
   input  logic [3:0]            ARID,
   input  logic [3:0]            ARLEN,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   // read data
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic                  RLAST,
   output logic [3:0]            RID,
   output logic [31:0]           RDATA,
   output logic                  wlast_err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [31:0] mem [DEPTH];

   r_state_t          r_state_reg, r_state_next;
   logic [3:0]        r_id_reg,    r_id_next;
   logic [3:0]        r_len_reg,   r_len_next;
   logic [3:0]        r_beat_reg,  r_beat_next;
   logic [3:0]        r_lat_reg,   r_lat_next;
   logic [IW-1:0]     r_idx_reg,   r_idx_next;

   w_state_t          w_state_reg, w_state_next;
   logic [3:0]        w_id_reg,    w_id_next;
   logic [3:0]        w_len_reg,   w_len_next;
   logic [3:0]        w_beat_reg,  w_beat_next;
   logic [IW-1:0]     w_idx_reg,   w_idx_next;
   logic              wlast_err_reg, wlast_err_next;

   logic              w_fire;
   logic              w_last_beat;
   logic              unused_inputs;

   // WID is not used for routing; only the low IW address bits select a word.
   assign unused_inputs = &{1'b0, WID, AWADDR, ARADDR};

   // ---------------- read engine ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_reg <= R_IDLE;
         r_id_reg    <= '0;
         r_len_reg   <= '0;
         r_beat_reg  <= '0;
         r_lat_reg   <= '0;
         r_idx_reg   <= '0;
      end else begin
         r_state_reg <= r_state_next;
         r_id_reg    <= r_id_next;
         r_len_reg   <= r_len_next;
         r_beat_reg  <= r_beat_next;
         r_lat_reg   <= r_lat_next;
         r_idx_reg   <= r_idx_next;
      end
   end

   always_comb begin
      r_state_next = r_state_reg;
      r_id_next    = r_id_reg;
      r_len_next   = r_len_reg;
      r_beat_next  = r_beat_reg;
      r_lat_next   = r_lat_reg;
      r_idx_next   = r_idx_reg;
      case (r_state_reg)
         R_IDLE: begin
            if (ARVALID) begin
               r_id_next   = ARID;
               r_len_next  = ARLEN;
               r_idx_next  = ARADDR[IW-1:0];
               r_beat_next = '0;
               r_lat_next  = 4'(READ_LATENCY);
               if (READ_LATENCY == 0) r_state_next = R_BURST;
               else                   r_state_next = R_WAIT;
            end
         end
         R_WAIT: begin
            // The final wait cycle is the one that sees a count of 1.
            r_lat_next = r_lat_reg - 4'd1;
            if (r_lat_reg <= 4'd1) r_state_next = R_BURST;
         end
         R_BURST: begin
            if (RREADY) begin
               if (r_beat_reg == r_len_reg) begin
                  r_state_next = R_IDLE;
               end else begin
                  r_idx_next  = r_idx_reg + 1'b1;
                  r_beat_next = r_beat_reg + 4'd1;
               end
            end
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   assign ARREADY = (r_state_reg == R_IDLE) && !rst;
   assign RVALID  = (r_state_reg == R_BURST);
   assign RLAST   = RVALID && (r_beat_reg == r_len_reg);
   assign RID     = r_id_reg;
   assign RDATA   = mem[r_idx_reg];

   // ---------------- write engine ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_reg   <= W_IDLE;
         w_id_reg      <= '0;
         w_len_reg     <= '0;
         w_beat_reg    <= '0;
         w_idx_reg     <= '0;
         wlast_err_reg <= 1'b0;
      end else begin
         w_state_reg   <= w_state_next;
         w_id_reg      <= w_id_next;
         w_len_reg     <= w_len_next;
         w_beat_reg    <= w_beat_next;
         w_idx_reg     <= w_idx_next;
         wlast_err_reg <= wlast_err_next;
      end
   end

   assign w_fire      = (w_state_reg == W_DATA) && WVALID;
   assign w_last_beat = (w_beat_reg == w_len_reg);

   always_comb begin
      w_state_next   = w_state_reg;
      w_id_next      = w_id_reg;
      w_len_next     = w_len_reg;
      w_beat_next    = w_beat_reg;
      w_idx_next     = w_idx_reg;
      wlast_err_next = wlast_err_reg;
      case (w_state_reg)
         W_IDLE: begin
            if (AWVALID) begin
               w_id_next    = AWID;
               w_len_next   = AWLEN;
               w_idx_next   = AWADDR[IW-1:0];
               w_beat_next  = '0;
               w_state_next = W_DATA;
            end
         end
         W_DATA: begin
            if (WVALID) begin
               w_idx_next  = w_idx_reg + 1'b1;
               w_beat_next = w_beat_reg + 4'd1;
               // Burst length comes from AWLEN; WLAST is only audited.
               if (WLAST != w_last_beat) wlast_err_next = 1'b1;
               if (w_last_beat) w_state_next = W_RESP;
            end
         end
         W_RESP: begin
            if (BREADY) w_state_next = W_IDLE;
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   // Memory contents survive reset.
   always_ff @(posedge clk) begin
      if (w_fire) mem[w_idx_reg] <= WDATA;
   end

   assign AWREADY   = (w_state_reg == W_IDLE) && !rst;
   assign WREADY    = (w_state_reg == W_DATA);
   assign BVALID    = (w_state_reg == W_RESP);
   assign BID       = w_id_reg;
   assign wlast_err = wlast_err_reg;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: expected R beats and B ids are queued
// when requests are issued and checked by a monitor as the handshakes occur.
`timescale 1ns/1ps

module tb_axi_mem_responder;

   localparam int DEPTH  = 1024;
   localparam int RL     = 4;
   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              AWVALID, AWREADY;
   logic [3:0]        AWID, AWLEN;
   logic [ADDR_W-1:0] AWADDR;
   logic              WVALID, WREADY, WLAST;
   logic [3:0]        WID;
   logic [31:0]       WDATA;
   logic              BVALID, BREADY;
   logic [3:0]        BID;
   logic              ARVALID, ARREADY;
   logic [3:0]        ARID, ARLEN;
   logic [ADDR_W-1:0] ARADDR;
   logic              RVALID, RREADY, RLAST;
   logic [3:0]        RID;
   logic [31:0]       RDATA;
   logic              wlast_err;

   axi_mem_responder #(
      .DEPTH(DEPTH), .READ_LATENCY(RL), .ADDR_WIDTH(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
      .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
      .wlast_err(wlast_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  id;
      logic        last;
   } r_beat_t;

   r_beat_t     r_exp [$];
   logic [3:0]  b_exp [$];
   logic [31:0] model [DEPTH];
   r_beat_t     mon_e;
   logic [3:0]  mon_b;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // R / B monitor
   always @(negedge clk) begin
      if (!rst && RVALID && RREADY) begin
         n_checks++;
         if (r_exp.size() == 0) begin
            n_fail++;
            $display("FAIL r_unexpected: got data=%h id=%0d last=%0b, required no beat", RDATA, RID, RLAST);
         end else begin
            mon_e = r_exp.pop_front();
            $display("R beat @%0d data=%h id=%0d last=%0b", cyc, RDATA, RID, RLAST);
            if ({RDATA, RID, RLAST} !== {mon_e.data, mon_e.id, mon_e.last}) begin
               n_fail++;
               $display("FAIL r_beat: got data=%h id=%0d last=%0b, required data=%h id=%0d last=%0b",
                        RDATA, RID, RLAST, mon_e.data, mon_e.id, mon_e.last);
            end
         end
      end
      if (!rst && BVALID && BREADY) begin
         n_checks++;
         if (b_exp.size() == 0) begin
            n_fail++;
            $display("FAIL b_unexpected: got id=%0d, required no response", BID);
         end else begin
            mon_b = b_exp.pop_front();
            $display("B resp @%0d id=%0d", cyc, BID);
            if (BID !== mon_b) begin
               n_fail++;
               $display("FAIL b_id: got %0d, required %0d", BID, mon_b);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic timeout_fail(input string what);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout, required handshake", what);
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [3:0] len, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] base, input int wlast_beat);
      int k;
      @(posedge clk); #1;
      AWVALID = 1'b1; AWID = id; AWLEN = len; AWADDR = addr;
      for (k = 0; k < 50; k++) begin @(negedge clk); if (AWREADY) break; end
      if (k == 50) timeout_fail("aw_wait");
      @(posedge clk); #1;
      AWVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         WVALID = 1'b1; WDATA = base + 32'(b); WLAST = (b == wlast_beat); WID = id;
         model[(int'(addr) + b) % DEPTH] = base + 32'(b);
         for (k = 0; k < 50; k++) begin @(negedge clk); if (WREADY) break; end
         if (k == 50) timeout_fail("w_wait");
         n_checks++;
         if (BVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b_early: got BVALID=%0b at beat %0d, required 0", BVALID, b);
         end
         @(posedge clk); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
      b_exp.push_back(id);
      @(negedge clk);
      n_checks++;
      if (BVALID !== 1'b1 || BID !== id) begin
         n_fail++;
         $display("FAIL b_after_last: got BVALID=%0b BID=%0d, required 1 and %0d", BVALID, BID, id);
      end
      $display("W burst id=%0d len=%0d addr=%h done", id, len, addr);
   endtask

   task automatic read_start(input logic [3:0] id, input logic [3:0] len, input logic [ADDR_W-1:0] addr,
                             output int hs_cyc);
      int k;
      @(posedge clk); #1;
      ARVALID = 1'b1; ARID = id; ARLEN = len; ARADDR = addr;
      for (int b = 0; b <= int'(len); b++)
         r_exp.push_back('{data: model[(int'(addr) + b) % DEPTH], id: id, last: (b == int'(len))});
      hs_cyc = -1;
      for (k = 0; k < 50; k++) begin @(negedge clk); if (ARREADY) break; end
      if (k == 50) timeout_fail("ar_wait");
      hs_cyc = cyc;
      @(posedge clk); #1;
      ARVALID = 1'b0;
      $display("AR id=%0d len=%0d addr=%h accepted @%0d", id, len, addr, hs_cyc);
   endtask

   task automatic wait_rvalid(output int at_cyc);
      int k;
      at_cyc = -1;
      for (k = 0; k < 50; k++) begin @(negedge clk); if (RVALID) break; end
      if (k == 50) timeout_fail("rvalid_wait");
      else at_cyc = cyc;
   endtask

   task automatic wait_drain(input string what);
      int k;
      for (k = 0; k < 200; k++) begin
         if (r_exp.size() == 0 && b_exp.size() == 0) break;
         @(negedge clk);
      end
      if (k == 200) timeout_fail(what);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0;
      WVALID = 0; WLAST = 0; WID = 0; WDATA = 0;
      BREADY = 1; ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0; RREADY = 1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, RID, BID, wlast_err} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got aw=%0b ar=%0b w=%0b b=%0b r=%0b rl=%0b rid=%0d bid=%0d err=%0b, required all 0",
                  AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, RID, BID, wlast_err);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (AWREADY !== 1'b1 || ARREADY !== 1'b1 || WREADY !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_ready: got aw=%0b ar=%0b w=%0b, required 1 1 0", AWREADY, ARREADY, WREADY);
      end
   endtask

   task automatic test_write_basic();
      write_burst(4'd3, 4'd3, 16'h0010, 32'hA0, 3);
      wait_drain("write_basic_drain");
      n_checks++;
      if (wlast_err !== 1'b0) begin
         n_fail++;
         $display("FAIL wlast_err_clean: got %0b, required 0", wlast_err);
      end
   endtask

   task automatic test_read_latency();
      int n, first;
      read_start(4'd5, 4'd3, 16'h0010, n);
      wait_rvalid(first);
      n_checks++;
      if (first !== n + 1 + RL) begin
         n_fail++;
         $display("FAIL read_latency: got first RVALID at %0d, required %0d", first, n + 1 + RL);
      end
      wait_drain("read_latency_drain");
   endtask

   task automatic test_stall();
      int n, first;
      RREADY = 1'b0;
      read_start(4'd5, 4'd3, 16'h0010, n);
      wait_rvalid(first);
      @(posedge clk); #1; RREADY = 1'b1;
      @(negedge clk);
      @(posedge clk); #1; RREADY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (RVALID !== 1'b1 || RDATA !== 32'hA1 || RLAST !== 1'b0 || RID !== 4'd5) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%0b data=%h last=%0b id=%0d, required 1 a1 0 5",
                     RVALID, RDATA, RLAST, RID);
         end
         @(posedge clk); #1;
      end
      RREADY = 1'b1;
      wait_drain("stall_drain");
   endtask

   task automatic test_wrap();
      int n;
      write_burst(4'd1, 4'd1, 16'(DEPTH - 1), 32'hB0, 1);
      wait_drain("wrap_write_drain");
      read_start(4'd1, 4'd1, 16'(DEPTH - 1), n);
      wait_drain("wrap_read_drain");
      read_start(4'd2, 4'd0, 16'h0000, n);
      wait_drain("wrap_read0_drain");
   endtask

   task automatic test_back_to_back();
      int k, n;
      logic seen;
      BREADY = 1'b0; RREADY = 1'b0;
      @(posedge clk); #1;
      AWVALID = 1'b1; AWID = 4'd6; AWLEN = 4'd0; AWADDR = 16'h0040;
      ARVALID = 1'b1; ARID = 4'd7; ARLEN = 4'd0; ARADDR = 16'h0010;
      r_exp.push_back('{data: model[16'h0010], id: 4'd7, last: 1'b1});
      @(negedge clk);
      n_checks++;
      if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL dual_accept: got aw=%0b ar=%0b, required 1 1", AWREADY, ARREADY);
      end
      @(posedge clk); #1;
      AWVALID = 1'b0; ARVALID = 1'b0;
      WVALID = 1'b1; WDATA = 32'hC0; WLAST = 1'b1;
      model[16'h0040] = 32'hC0;
      for (k = 0; k < 50; k++) begin @(negedge clk); if (WREADY) break; end
      if (k == 50) timeout_fail("dual_w_wait");
      @(posedge clk); #1;
      WVALID = 1'b0; WLAST = 1'b0;
      b_exp.push_back(4'd6);
      seen = 1'b0;
      for (k = 0; k < 30; k++) begin
         @(negedge clk);
         if (BVALID && RVALID) begin seen = 1'b1; break; end
      end
      n_checks++;
      if (seen !== 1'b1) begin
         n_fail++;
         $display("FAIL b_r_overlap: got overlap=%0b, required 1", seen);
      end
      @(posedge clk); #1;
      BREADY = 1'b1; RREADY = 1'b1;
      wait_drain("dual_drain");
      read_start(4'd8, 4'd0, 16'h0040, n);
      wait_drain("dual_readback_drain");
   endtask

   task automatic test_wlast_err_and_abort();
      int n, first;
      write_burst(4'd2, 4'd3, 16'h0020, 32'hD0, 1);
      wait_drain("wlast_write_drain");
      n_checks++;
      if (wlast_err !== 1'b1) begin
         n_fail++;
         $display("FAIL wlast_err_set: got %0b, required 1", wlast_err);
      end
      RREADY = 1'b0;
      read_start(4'd4, 4'd3, 16'h0020, n);
      wait_rvalid(first);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (RVALID !== 1'b0 || ARREADY !== 1'b0 || wlast_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort: got RVALID=%0b ARREADY=%0b err=%0b, required 0 0 0", RVALID, ARREADY, wlast_err);
      end
      r_exp.delete();
      b_exp.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      RREADY = 1'b1;
      read_start(4'd9, 4'd0, 16'h0010, n);
      read_start(4'd10, 4'd3, 16'h0020, n);
      wait_drain("post_abort_drain");
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_latency();
      test_stall();
      test_wrap();
      test_back_to_back();
      test_wlast_err_and_abort();
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 1024, giving the number of 32-bit memory words; it SHALL be a power of 2.
REQ-002 The block SHALL have the parameter READ_LATENCY, default 4, giving the idle cycles between AR acceptance and the first R beat; legal values are 0..15.
REQ-003 The block SHALL have the parameter ADDR_WIDTH, default `ADDR_WIDTH, giving the AWADDR/ARADDR width; addresses are word addresses.
REQ-004 The block SHALL have the ports clk in 1 (clock) and rst in 1 (reset); there is one clock, and reset is asynchronous and active-high.
REQ-005 The block SHALL have the AW ports AWVALID in 1, AWREADY out 1, AWID in 4, AWLEN in 4 (beats-1) and AWADDR in ADDR_WIDTH.
REQ-006 The block SHALL have the W ports WVALID in 1, WREADY out 1, WLAST in 1, WID in 4 (ignored) and WDATA in 32.
REQ-007 The block SHALL have the B ports BVALID out 1, BREADY in 1 and BID out 4.
REQ-008 The block SHALL have the AR ports ARVALID in 1, ARREADY out 1, ARID in 4, ARLEN in 4 (beats-1) and ARADDR in ADDR_WIDTH.
REQ-009 The block SHALL have the R ports RVALID out 1, RREADY in 1, RLAST out 1, RID out 4 and RDATA out 32.
REQ-010 The block SHALL have the port wlast_err out 1, a sticky flag for WLAST protocol mismatch.

Function
REQ-011 The block SHALL be an AXI subordinate: it responds to the core's memory arbiter, and the read and write channels SHALL operate fully independently and concurrently.
REQ-012 The memory index SHALL be addr[log2(DEPTH)-1:0]; burst addresses SHALL increment by 1 per beat and wrap modulo DEPTH.
REQ-013 The read FSM SHALL have three states, with these transitions:
- R_IDLE, where ARREADY=1; on ARVALID&ARREADY it latches ARID/ARLEN/ARADDR, clears the beat count and loads the latency count with READ_LATENCY, then goes to R_WAIT (or directly to R_BURST if READ_LATENCY=0).
- R_WAIT, where ARREADY=0 and RVALID=0; the count decrements each cycle, and the FSM goes to R_BURST when the count reaches 0.
- R_BURST, where RVALID=1, RID=latched ID, RDATA=mem[read index] and RLAST=(beat==len).
REQ-014 With AR handshake at cycle N, the first RVALID SHALL be at cycle N+1+READ_LATENCY.
REQ-015 On an R handshake that is not last, the read index and beat SHALL increment; on the last beat the FSM SHALL return to R_IDLE.
REQ-016 While RVALID=1 and RREADY=0, RDATA/RID/RLAST SHALL hold stable.
REQ-017 The write FSM SHALL have three states, with these transitions:
- W_IDLE, where AWREADY=1; on the AW handshake it latches AWID/AWLEN/AWADDR, clears the beat count and goes to W_DATA.
- W_DATA, where WREADY=1; each W handshake writes WDATA to mem[write index] at the clock edge and increments the index and beat; after beat==len is accepted, the FSM goes to W_RESP.
- W_RESP, where BVALID=1 and BID=latched ID; on BREADY it returns to W_IDLE.
REQ-018 The burst SHALL terminate on the beat count, not on WLAST.
REQ-019 wlast_err SHALL be set on any accepted beat where WLAST != (beat==len), and SHALL clear only on reset.
REQ-020 A memory write at edge N SHALL be visible on RDATA from cycle N+1, including a read burst in progress at the same index (no bypass within the same cycle).
REQ-021 Simultaneous AR and AW handshakes in the same cycle SHALL both be accepted.
REQ-022 Burst length SHALL be AxLEN+1, in the range 1..16.

Reset
REQ-023 While rst=1, the block SHALL be in R_IDLE/W_IDLE, with AWREADY=0, ARREADY=0, WREADY=0, BVALID=0, RVALID=0, RLAST=0, RID=0, BID=0, wlast_err=0 and all counters 0.
REQ-024 In the first cycle after rst deasserts, AWREADY=1 and ARREADY=1.
REQ-025 rst asserted mid-burst SHALL abort both FSMs immediately; memory contents SHALL NOT be cleared by reset.

Verification
REQ-026 The bench SHALL cover: AW(id=3,len=3,addr=0x10) and W data 0xA0..0xA3 with WLAST on beat 4 -> BVALID=1, BID=3 on the cycle after beat 4, and wlast_err=0.
REQ-027 The bench SHALL cover: AR(id=5,len=3,addr=0x10) at cycle N with READ_LATENCY=4 -> RVALID first at N+5, RDATA 0xA0,0xA1,0xA2,0xA3, RID=5 and RLAST only on the 4th beat.
REQ-028 The bench SHALL cover: RREADY held low for 3 cycles during the 2nd beat -> RDATA stays 0xA1 and RVALID stays 1.
REQ-029 The bench SHALL cover: a write burst at addr=DEPTH-1 with len=1 -> the beats land at DEPTH-1 and at 0, and reading back at DEPTH-1 with len=1 returns both.
REQ-030 The bench SHALL cover: AR and AW handshakes in the same cycle -> both complete, and BVALID and RVALID overlap in time.
REQ-031 The bench SHALL cover: WLAST asserted on beat 2 of a len=3 burst -> wlast_err=1, the burst still accepts 4 beats, and rst asserted mid-read-burst forces RVALID=0 immediately.
